uart_rx_param: RTL and testbench

Parametrised UART receiver, next generation of the board's fixed 3 Mbaud, 8N1 receiver. Baud divisor, data width and stop-bit count are set by parameters. The block adds mid-bit sampling, a framing-error report, an optional parity check and an inter-block idle timeout. It sits between the board `uart_rx` pin and the RX FIFO write port of the I/O protocol controller.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_sync.sv | 25 ++
 rtl/uart_rx_param.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, 27 MHz board baud constants and the
// mid-bit offset helper shared by the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int CLK_HZ_BOARD    = 27_000_000;
  localparam int BAUD_3M         = 3_000_000;
  localparam int CLKS_PER_BIT_3M = CLK_HZ_BOARD / BAUD_3M;

  // Offset from the start edge to the middle of the start bit.
  function automatic int half_of(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// uart_bit_sync: 2-flop synchronizer for the serial pin; resets to the idle
// (high) line level so reset never looks like a start bit.
module uart_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with mid-bit sampling, framing and
// parity error pulses and an idle timeout. Parity check under UART_RX_PARITY_EN.
//
// state      | meaning
// IDLE       | line idle, waiting for a low rx_s
// START      | counting to mid start bit, rejects glitches
// DATA       | sampling DATA_BITS payload bits, LSB first
// PARITY     | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP       | sampling STOP_BITS stop bits, issuing the result pulse
// WAIT_IDLE  | framing lost, waiting for the line to go high
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_3M,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int IDLE_TIMEOUT = 180
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_bsy,
  output logic                 block_timeout
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CW-1:0] C_HALF      = CW'(half_of(CLKS_PER_BIT));
  localparam logic [CW-1:0] C_LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [TW-1:0] T_LIMIT     = TW'(IDLE_TIMEOUT);

  localparam logic [2:0] S_IDLE      = ST_IDLE;
  localparam logic [2:0] S_START     = ST_START;
  localparam logic [2:0] S_DATA      = ST_DATA;
  localparam logic [2:0] S_STOP      = ST_STOP;
  localparam logic [2:0] S_WAIT_IDLE = ST_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = ST_PARITY;
  localparam logic       P_ODD       = (PARITY_ODD != 0);
`endif

  logic                 w_rx_s;
  logic                 w_sample;
  logic [TW-1:0]        w_idle_nxt;
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic [TW-1:0]        r_idle_cnt;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_stop_bad;
  logic                 r_armed;
  logic                 r_timeout;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr;
  logic                 r_perr_pulse;
`endif

  uart_bit_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  assign w_sample = (r_cnt == C_LAST);

  // Idle counter only runs while sitting in IDLE on a high line; it saturates.
  always_comb begin
    w_idle_nxt = '0;
    if (r_state == S_IDLE && w_rx_s) begin
      w_idle_nxt = (r_idle_cnt == T_LIMIT) ? r_idle_cnt : r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_idle_cnt <= '0;
      r_valid    <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_bad <= 1'b0;
      r_armed    <= 1'b0;
      r_timeout  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr       <= 1'b0;
      r_perr_pulse <= 1'b0;
`endif
    end else begin
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_timeout <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr_pulse <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr     <= 1'b0;
`endif
          end
        end
        S_START: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_HALF) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_sample) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == B_DATA_LAST) begin
              r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= S_PARITY;
`else
              r_state   <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_sample) begin
            r_cnt   <= '0;
            r_perr  <= (w_rx_s != ((^r_shift) ^ P_ODD));
            r_state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_sample) begin
            r_cnt     <= '0;
            r_bit_idx <= r_bit_idx + 1'b1;
            if (!w_rx_s) r_stop_bad <= 1'b1;
            if (r_bit_idx == B_STOP_LAST) begin
              r_bit_idx <= '0;
              r_armed   <= 1'b1;
              if (r_stop_bad || !w_rx_s) begin
                r_ferr  <= 1'b1;
                r_state <= S_WAIT_IDLE;
              end
`ifdef UART_RX_PARITY_EN
              else if (r_perr) begin
                r_perr_pulse <= 1'b1;
                r_state      <= S_IDLE;
              end
`endif
              else begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_WAIT_IDLE: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Pulse lands in the cycle where the counter reads IDLE_TIMEOUT.
      r_idle_cnt <= w_idle_nxt;
      if (r_armed && w_idle_nxt == T_LIMIT && r_idle_cnt != T_LIMIT) begin
        r_timeout <= 1'b1;
        r_armed   <= 1'b0;
      end
    end
  end

  assign data_valid    = r_valid;
  assign data_out      = r_data;
  assign frame_err     = r_ferr;
  assign rx_bsy        = (r_state != S_IDLE);
  assign block_timeout = r_timeout;
`ifdef UART_RX_PARITY_EN
  assign parity_err    = r_perr_pulse;
`else
  assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for uart_rx_param; frames are described as
// bit lists and expected pulses (kind, cycle, data) are queued for the monitor.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int CPB  = 9;
  localparam int DB   = 8;
  localparam int SB   = 1;
  localparam int PODD = 1;
  localparam int TO   = 180;
  localparam int HALF = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NS = DB + P + SB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          rx_bsy;
  logic          block_timeout;
  logic [DB-1:0] data_out;

  uart_rx_param #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .STOP_BITS    (SB),
    .PARITY_ODD   (PODD),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .data_valid    (data_valid),
    .data_out      (data_out),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .rx_bsy        (rx_bsy),
    .block_timeout (block_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            kind;  // 0 valid, 1 frame_err, 2 parity_err, 3 timeout
    logic [DB-1:0] data;
    int            at;
  } exp_t;

  exp_t          sb[$];
  int            n_tests = 0;
  int            n_fail = 0;
  logic [DB-1:0] last_clean = '0;
  int            last_done = 0;
  logic [DB-1:0] prev_data = '0;
  logic          prev_bsy = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic par_bit(input logic [DB-1:0] d);
    return logic'(($countones(d) + PODD) % 2);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic pbit, input logic stop_ok);
    int   bits[$];
    exp_t e;
    bits.push_back(0);
    for (int i = 0; i < DB; i++) bits.push_back(int'(d[i]));
    if (P == 1) bits.push_back(int'(pbit));
    for (int i = 0; i < SB; i++) bits.push_back(int'(stop_ok));
    if (!stop_ok)                        e.kind = 1;
    else if (P == 1 && pbit != par_bit(d)) e.kind = 2;
    else                                 e.kind = 0;
    e.at   = cyc + 4 + HALF + NS * CPB;
    e.data = (e.kind == 0) ? d : last_clean;
    if (e.kind == 0) last_clean = d;
    if (e.kind != 1) last_done = e.at;
    sb.push_back(e);
    foreach (bits[i]) begin
      rx = logic'(bits[i]);
      tick(CPB);
    end
  endtask

  task automatic expect_timeout();
    exp_t e;
    e.kind = 3;
    e.data = last_clean;
    e.at   = last_done + TO;
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_valid"}, int'(data_valid), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_parity_err"}, int'(parity_err), 0);
    check({tag, "_block_timeout"}, int'(block_timeout), 0);
    check({tag, "_rx_bsy"}, int'(rx_bsy), 0);
    check({tag, "_data_out"}, int'(data_out), 0);
  endtask

  // Monitor: pops one expectation per output pulse.
  initial begin
    exp_t e;
    int   np;
    int   k;
    forever begin
      @(negedge clk);
      np = int'(data_valid) + int'(frame_err) + int'(parity_err) + int'(block_timeout);
      if (np > 0) begin
        k = data_valid ? 0 : frame_err ? 1 : parity_err ? 2 : 3;
        check("pulse_exclusive", np, 1);
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pulse: actual kind %0d at cycle %0d, required none", k, cyc);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", k, e.kind);
          check("pulse_cycle", cyc, e.at);
          check("pulse_data_out", int'(data_out), int'(e.data));
          if (k == 0 || k == 2) begin
            check("bsy_before_pulse", int'(prev_bsy), 1);
            check("bsy_at_pulse", int'(rx_bsy), 0);
          end
          if (k == 1) check("bsy_after_frame_err", int'(rx_bsy), 1);
        end
      end
      if (rst_n && data_out != prev_data && !data_valid) begin
        n_tests++;
        n_fail++;
        $display("FAIL data_out_stable: actual %0h required %0h", data_out, prev_data);
      end
      prev_data = data_out;
      prev_bsy  = rx_bsy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int            e0;
    logic [DB-1:0] d;
    logic          stop_ok;
    int            gap;

    // Reset state.
    tick(3);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);

    // Start glitch: 3 low cycles, rejected at mid start bit.
    e0 = cyc;
    rx = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("glitch_bsy_t0", int'(rx_bsy), 0);
    @(posedge clk);
    #1;
    rx = 1'b1;
    @(negedge clk);
    check("glitch_bsy_t0p1", int'(rx_bsy), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("glitch_bsy_last", int'(rx_bsy), 1);
    @(posedge clk);
    @(negedge clk);
    check("glitch_bsy_release", int'(rx_bsy), 0);
    check("glitch_cycle_ref", cyc - e0, 8);
    @(posedge clk);
    #1;
    idle(5);

    // 0xA5 then back-to-back 0x00, 0xFF, 0x55, then one idle timeout.
    send_frame(8'hA5, par_bit(8'hA5), 1'b1);
    send_frame(8'h00, par_bit(8'h00), 1'b1);
    send_frame(8'hFF, par_bit(8'hFF), 1'b1);
    send_frame(8'h55, par_bit(8'h55), 1'b1);
    expect_timeout();
    idle(TO + 60);

    // 0x3C with a low stop bit; busy held while the line stays low.
    send_frame(8'h3C, par_bit(8'h3C), 1'b0);
    tick(20);
    @(negedge clk);
    check("ferr_bsy_hold", int'(rx_bsy), 1);
    @(posedge clk);
    #1;
    idle(4);
    @(negedge clk);
    check("ferr_bsy_release", int'(rx_bsy), 0);
    @(posedge clk);
    #1;
    idle(3);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b0, 1'b1);
    idle(3);
    send_frame(8'h01, 1'b1, 1'b1);
    idle(3);
`endif

    // Randomized frames with short gaps; the last one is clean.
    for (int i = 0; i < 30; i++) begin
      d       = DB'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0) || (i == 29);
      send_frame(d, par_bit(d) ^ ($urandom_range(0, 4) == 0), stop_ok);
      gap = stop_ok ? $urandom_range(0, 6) : $urandom_range(1, 6);
      if (gap > 0) idle(gap);
    end
    expect_timeout();
    idle(TO + 60);

    // Reset in the middle of the data bits of 0x81.
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(CPB);
    rx = 1'b0;
    tick(CPB);
    tick(CPB);
    rst_n = 1'b0;
    rx    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midframe_reset");
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    last_clean = '0;
    idle(4);
    send_frame(8'h7E, par_bit(8'h7E), 1'b1);
    expect_timeout();
    idle(TO + 60);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
